// File: rtl/sample_uart_framer.sv
// sample_uart_framer: decimates new-sample strobes and sends each kept LED pair as an 8-byte checksummed UART frame
//   clk            : system clock, all logic on the rising edge
//   reset_n        : synchronous active-low reset
//   in_new_samples : new-sample level from the buffer; its rising edge is one event
//   in_led_one/two : signed 22-bit samples, captured on a kept event
//   out_tx_byte    : byte presented to the UART transmitter (held until the next byte)
//   out_tx_dv      : one-cycle start strobe for out_tx_byte
//   in_tx_done     : UART byte complete; its rising edge acknowledges the byte
//   out_busy       : frame in progress
//   out_frame_sent : one-cycle pulse after the 8th byte is acknowledged
//   out_timeout    : one-cycle pulse when a frame is abandoned for lack of acknowledge
//   out_drop_count : saturating count of kept events lost while a frame was in progress
module sample_uart_framer #(
    parameter int unsigned DOWNSAMPLE     = 13,
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_new_samples,
    input  logic [21:0] in_led_one,
    input  logic [21:0] in_led_two,
    output logic [7:0]  out_tx_byte,
    output logic        out_tx_dv,
    input  logic        in_tx_done,
    output logic        out_busy,
    output logic        out_frame_sent,
    output logic        out_timeout,
    output logic [7:0]  out_drop_count
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t      state_q, state_d;
    logic        prev_new_q, prev_done_q;
    logic [7:0]  dcnt_q, dcnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] timer_q, timer_d;
    logic [21:0] led_one_q, led_one_d, led_two_q, led_two_d;
    logic [7:0]  byte_q, byte_d, drop_q, drop_d;
    logic        dv_q, dv_d, busy_q, busy_d, sent_q, sent_d, tout_q, tout_d;
    logic        rise, kept, done_rise;
    logic [23:0] ext_one, ext_two;
    logic [7:0]  sum6, csum, cur_byte;

    assign rise      = in_new_samples & ~prev_new_q;
    assign kept      = rise && (dcnt_q == 8'(DOWNSAMPLE - 1));
    assign done_rise = in_tx_done & ~prev_done_q;

    // Frame bytes are derived from the latched samples, so the inputs may change mid-frame.
    assign ext_one = {{2{led_one_q[21]}}, led_one_q};
    assign ext_two = {{2{led_two_q[21]}}, led_two_q};
    assign sum6    = ext_one[23:16] + ext_one[15:8] + ext_one[7:0]
                   + ext_two[23:16] + ext_two[15:8] + ext_two[7:0];
    assign csum    = 8'd0 - sum6;

    always_comb begin
        cur_byte = HEADER;
        case (idx_q)
            3'd1:    cur_byte = ext_one[23:16];
            3'd2:    cur_byte = ext_one[15:8];
            3'd3:    cur_byte = ext_one[7:0];
            3'd4:    cur_byte = ext_two[23:16];
            3'd5:    cur_byte = ext_two[15:8];
            3'd6:    cur_byte = ext_two[7:0];
            3'd7:    cur_byte = csum;
            default: cur_byte = HEADER;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = rise ? (kept ? 8'd0 : dcnt_q + 8'd1) : dcnt_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        led_one_d = led_one_q;
        led_two_d = led_two_q;
        byte_d    = byte_q;
        drop_d    = (kept && state_q != IDLE && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        dv_d      = 1'b0;
        busy_d    = busy_q;
        sent_d    = 1'b0;
        tout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (kept) begin
                    led_one_d = in_led_one;
                    led_two_d = in_led_two;
                    busy_d    = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                dv_d    = 1'b1;
                byte_d  = cur_byte;
                timer_d = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                // An acknowledge wins over a timeout expiring on the same edge.
                if (done_rise) begin
                    idx_d   = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
                    sent_d  = (idx_q == 3'd7);
                    busy_d  = (idx_q != 3'd7);
                    state_d = (idx_q == 3'd7) ? IDLE : SEND;
                end else if (timer_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    tout_d  = 1'b1;
                    idx_d   = 3'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            prev_new_q  <= 1'b0;
            prev_done_q <= 1'b0;
            dcnt_q      <= 8'd0;
            idx_q       <= 3'd0;
            timer_q     <= 16'd0;
            led_one_q   <= 22'd0;
            led_two_q   <= 22'd0;
            byte_q      <= 8'd0;
            drop_q      <= 8'd0;
            dv_q        <= 1'b0;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_new_q  <= in_new_samples;
            prev_done_q <= in_tx_done;
            dcnt_q      <= dcnt_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            led_one_q   <= led_one_d;
            led_two_q   <= led_two_d;
            byte_q      <= byte_d;
            drop_q      <= drop_d;
            dv_q        <= dv_d;
            busy_q      <= busy_d;
            sent_q      <= sent_d;
            tout_q      <= tout_d;
        end
    end

    assign out_tx_byte    = byte_q;
    assign out_tx_dv      = dv_q;
    assign out_busy       = busy_q;
    assign out_frame_sent = sent_q;
    assign out_timeout    = tout_q;
    assign out_drop_count = drop_q;
endmodule

// File: tb/tb_sample_uart_framer.sv
// tb_sample_uart_framer: scoreboard bench for two framer instances (DOWNSAMPLE=1/TIMEOUT=50 and DOWNSAMPLE=13/TIMEOUT=65535)
module tb_sample_uart_framer;
    typedef struct {
        int         cyc;
        int         kind;   // 0 = byte strobe, 1 = frame sent, 2 = timeout
        logic [7:0] b;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       ns = '0;
    logic [1:0][21:0] l1 = '0;
    logic [1:0][21:0] l2 = '0;
    logic [1:0]       man_done = '0;
    logic [1:0]       auto_done = '0;
    logic [1:0]       done;
    logic [1:0][7:0]  tx_byte, drop;
    logic [1:0]       dv, busy, sent, tout;

    assign done = man_done | auto_done;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sample_uart_framer #(
            .DOWNSAMPLE    (g == 0 ? 1 : 13),
            .HEADER        (8'hA5),
            .TIMEOUT_CYCLES(g == 0 ? 50 : 65535)
        ) dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .in_new_samples(ns[g]),
            .in_led_one    (l1[g]),
            .in_led_two    (l2[g]),
            .out_tx_byte   (tx_byte[g]),
            .out_tx_dv     (dv[g]),
            .in_tx_done    (done[g]),
            .out_busy      (busy[g]),
            .out_frame_sent(sent[g]),
            .out_timeout   (tout[g]),
            .out_drop_count(drop[g])
        );
    end

    function automatic int ds_of(input int i);
        return (i == 0) ? 1 : 13;
    endfunction

    function automatic int to_of(input int i);
        return (i == 0) ? 50 : 65535;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp_v, exp_v);
        end
    endtask

    // ---------------- reference model (timestamp based) ----------------
    int         cyc = 0;
    ev_t        exp_q[2][$];
    int         m_ev[2], m_idx[2], m_dv_at[2], m_drops[2];
    int         m_rst_cyc[2] = '{-1, -1};
    bit         m_active[2], m_pns[2], m_pdone[2];
    logic [7:0] m_frame[2][8];

    function automatic void push(input int i, input int c, input int k, input logic [7:0] b);
        ev_t e;
        e.cyc = c; e.kind = k; e.b = b;
        exp_q[i].push_back(e);
    endfunction

    initial begin
        bit rise, drise, kept;
        int va, vb, s;
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (!reset_n) begin
                    while (exp_q[i].size() > 0 && exp_q[i][$].cyc >= cyc) void'(exp_q[i].pop_back());
                    m_active[i] = 0; m_pns[i] = 0; m_pdone[i] = 0;
                    m_ev[i] = 0; m_drops[i] = 0; m_idx[i] = 0; m_rst_cyc[i] = cyc;
                end else begin
                    rise  = ns[i] && !m_pns[i];
                    drise = done[i] && !m_pdone[i];
                    m_pns[i] = ns[i];
                    m_pdone[i] = done[i];
                    kept = 0;
                    if (rise) begin
                        m_ev[i]++;
                        kept = (m_ev[i] % ds_of(i)) == 0;
                    end
                    if (m_active[i]) begin
                        if (kept && m_drops[i] < 255) m_drops[i]++;
                        if (cyc > m_dv_at[i]) begin
                            if (drise) begin
                                if (m_idx[i] == 7) begin
                                    push(i, cyc, 1, 8'h00);
                                    m_active[i] = 0;
                                end else begin
                                    m_idx[i]++;
                                    m_dv_at[i] = cyc + 1;
                                    push(i, cyc + 1, 0, m_frame[i][m_idx[i]]);
                                end
                            end else if (cyc - m_dv_at[i] == to_of(i)) begin
                                push(i, cyc, 2, 8'h00);
                                m_active[i] = 0;
                            end
                        end
                    end else if (kept) begin
                        va = $signed(l1[i]);
                        vb = $signed(l2[i]);
                        m_frame[i][0] = 8'hA5;
                        for (int k = 0; k < 3; k++) begin
                            m_frame[i][1 + k] = 8'((va >> (16 - 8 * k)) & 255);
                            m_frame[i][4 + k] = 8'((vb >> (16 - 8 * k)) & 255);
                        end
                        s = 0;
                        for (int k = 1; k < 7; k++) s += int'(m_frame[i][k]);
                        m_frame[i][7] = 8'((256 - s % 256) % 256);
                        m_active[i] = 1;
                        m_idx[i] = 0;
                        m_dv_at[i] = cyc + 1;
                        push(i, cyc + 1, 0, m_frame[i][0]);
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [7:0] exp_byte[2];
    int         n_dv[2], n_sent[2], n_to[2], last_dv_cyc[2], last_to_cyc[2];
    logic [7:0] last_dv_byte[2];
    logic [7:0] log0[$];

    initial begin
        bit  e_dv, e_sent, e_to;
        ev_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                e_dv = 0; e_sent = 0; e_to = 0;
                if (m_rst_cyc[i] == cyc) exp_byte[i] = 8'h00;
                while (exp_q[i].size() > 0 && exp_q[i][0].cyc <= cyc) begin
                    e = exp_q[i].pop_front();
                    if (e.kind == 0) begin
                        e_dv = 1;
                        exp_byte[i] = e.b;
                    end else if (e.kind == 1) e_sent = 1;
                    else e_to = 1;
                end
                check($sformatf("dv[%0d]@%0d", i, cyc), dv[i], e_dv);
                check($sformatf("frame_sent[%0d]@%0d", i, cyc), sent[i], e_sent);
                check($sformatf("timeout[%0d]@%0d", i, cyc), tout[i], e_to);
                check($sformatf("tx_byte[%0d]@%0d", i, cyc), tx_byte[i], exp_byte[i]);
                check($sformatf("busy[%0d]@%0d", i, cyc), busy[i], m_active[i]);
                check($sformatf("drop_count[%0d]@%0d", i, cyc), drop[i], m_drops[i]);
                if (dv[i]) begin
                    n_dv[i]++;
                    last_dv_cyc[i] = cyc;
                    last_dv_byte[i] = tx_byte[i];
                    if (i == 0) log0.push_back(tx_byte[0]);
                end
                if (sent[i]) n_sent[i]++;
                if (tout[i]) begin
                    n_to[i]++;
                    last_to_cyc[i] = cyc;
                end
            end
        end
    end

    // ---------------- UART done responder ----------------
    bit auto_en[2] = '{1, 1};
    int ack_lo[2] = '{20, 20};
    int ack_hi[2] = '{20, 20};
    int hold_lo[2] = '{2, 2};
    int hold_hi[2] = '{2, 2};
    int ack_cnt[2], hold[2];

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                ack_cnt[i] = 0; hold[i] = 0; auto_done[i] = 1'b0;
            end else begin
                if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) auto_done[i] = 1'b0;
                end else if (ack_cnt[i] > 0) begin
                    ack_cnt[i]--;
                    if (ack_cnt[i] == 0) begin
                        auto_done[i] = 1'b1;
                        hold[i] = $urandom_range(hold_hi[i], hold_lo[i]);
                    end
                end
                if (dv[i] && auto_en[i]) ack_cnt[i] = $urandom_range(ack_hi[i], ack_lo[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic int cnt_of(input int which, input int i);
        return (which == 0) ? n_dv[i] : (which == 1) ? n_sent[i] : n_to[i];
    endfunction

    task automatic wait_cnt(input string name, input int which, input int i, input int target, input int limit);
        for (int n = 0; n < limit && cnt_of(which, i) < target; n++) @(negedge clk);
        check(name, cnt_of(which, i) >= target, 1);
    endtask

    task automatic wait_idle(input string name, input int i, input int limit);
        for (int n = 0; n < limit && busy[i]; n++) @(negedge clk);
        check(name, busy[i], 0);
    endtask

    task automatic strobe(input int i, input int hi, input logic [21:0] a, input logic [21:0] b);
        ns[i] = 1'b1; l1[i] = a; l2[i] = b;
        repeat (hi) @(negedge clk);
        ns[i] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp1[8] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h23, 8'hDF};
        int b, s0, d0;
        int rem[2] = '{0, 0};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_tx_byte", tx_byte[i], 0);
            check("reset_dv", dv[i], 0);
            check("reset_busy", busy[i], 0);
            check("reset_sent", sent[i], 0);
            check("reset_timeout", tout[i], 0);
            check("reset_drop", drop[i], 0);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // single frame, known bytes
        log0.delete();
        strobe(0, 1, 22'h3FFFFF, 22'h000123);
        wait_cnt("t1_sent", 1, 0, 1, 400);
        @(negedge clk);
        check("t1_dv_count", n_dv[0], 8);
        check("t1_sent_count", n_sent[0], 1);
        check("t1_drop", drop[0], 0);
        check("t1_log_len", log0.size(), 8);
        for (int k = 0; k < 8 && k < log0.size(); k++) check($sformatf("t1_byte%0d", k), log0[k], exp1[k]);

        // decimation by 13
        b = n_dv[1];
        for (int k = 1; k <= 26; k++) begin
            strobe(1, 2, 22'($urandom), 22'($urandom));
            repeat (248) @(negedge clk);
            if (k == 12) check("t2_no_dv_before_13", n_dv[1] - b, 0);
            if (k == 13) check("t2_frame_on_13", n_dv[1] - b, 8);
        end
        check("t2_dv_total", n_dv[1] - b, 16);
        check("t2_sent_total", n_sent[1], 2);

        // three drops during one frame
        d0 = drop[0]; s0 = n_sent[0];
        strobe(0, 1, 22'h1ABCDE, 22'h200001);
        for (int k = 0; k < 3; k++) begin
            strobe(0, 1, 22'($urandom), 22'($urandom));
            repeat (10) @(negedge clk);
        end
        wait_cnt("t3_sent", 1, 0, s0 + 1, 400);
        check("t3_drop", drop[0] - d0, 3);

        // saturation with no acknowledge
        auto_en[0] = 0;
        for (int k = 0; k < 300; k++) strobe(0, 1, 22'($urandom), 22'($urandom));
        check("t4_drop_saturated", drop[0], 255);
        wait_idle("t4_idle", 0, 200);

        // timeout 50 cycles after the byte strobe, then restart at the header
        b = n_to[0];
        strobe(0, 1, 22'h00ABCD, 22'h2FFFFF);
        wait_cnt("t5_timeout", 2, 0, b + 1, 200);
        check("t5_timeout_gap", last_to_cyc[0] - last_dv_cyc[0], 50);
        check("t5_busy_low", busy[0], 0);
        repeat (60) @(negedge clk);
        auto_en[0] = 1;
        b = n_dv[0]; s0 = n_sent[0];
        strobe(0, 1, 22'h012345, 22'h3EDCBA);
        wait_cnt("t5_restart_dv", 0, 0, b + 1, 50);
        check("t5_restart_header", last_dv_byte[0], 8'hA5);
        wait_cnt("t5_restart_sent", 1, 0, s0 + 1, 400);

        // reset while B4 is pending, decimation counter restarts
        for (int k = 0; k < 5; k++) strobe(1, 1, 22'($urandom), 22'($urandom));
        ack_lo[0] = 5; ack_hi[0] = 5;
        b = n_dv[0];
        strobe(0, 1, 22'h155555, 22'h2AAAAA);
        wait_cnt("t6_b4_dv", 0, 0, b + 5, 200);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("t6_tx_byte", tx_byte[i], 0);
            check("t6_dv", dv[i], 0);
            check("t6_busy", busy[i], 0);
            check("t6_sent", sent[i], 0);
            check("t6_timeout", tout[i], 0);
            check("t6_drop", drop[i], 0);
        end
        s0 = n_sent[0]; d0 = n_to[0]; b = n_dv[0];
        repeat (30) @(negedge clk);
        check("t6_no_sent", n_sent[0] - s0, 0);
        check("t6_no_timeout", n_to[0] - d0, 0);
        check("t6_no_dv", n_dv[0] - b, 0);
        b = n_dv[1]; s0 = n_sent[1];
        for (int k = 1; k <= 12; k++) strobe(1, 1, 22'($urandom), 22'($urandom));
        check("t6_dcnt_restart", n_dv[1] - b, 0);
        strobe(1, 1, 22'h3FFF00, 22'h0000FF);
        wait_cnt("t6_frame_on_13", 1, 1, s0 + 1, 400);

        // kept strobe coincident with the final acknowledge
        auto_en[0] = 0;
        b = n_dv[0]; s0 = n_sent[0]; d0 = drop[0];
        strobe(0, 1, 22'h2468AC, 22'h13579B);
        for (int k = 0; k < 8; k++) begin
            wait_cnt("t7_dv", 0, 0, b + k + 1, 100);
            repeat (3) @(negedge clk);
            if (k == 7) ns[0] = 1'b1;
            man_done[0] = 1'b1;
            @(negedge clk);
            man_done[0] = 1'b0;
            ns[0] = 1'b0;
        end
        @(negedge clk);
        check("t7_drop", drop[0] - d0, 1);
        check("t7_sent", n_sent[0] - s0, 1);
        repeat (20) @(negedge clk);
        check("t7_no_new_frame", n_dv[0] - b, 8);
        check("t7_idle", busy[0], 0);

        // randomized traffic on both instances, random acknowledge delays
        auto_en[0] = 1; auto_en[1] = 1;
        ack_lo = '{1, 1}; ack_hi = '{60, 12};
        hold_lo = '{1, 1}; hold_hi = '{3, 3};
        repeat (4000) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) ns[i] = 1'b0;
                end else if (!ns[i] && $urandom_range(19, 0) == 0) begin
                    ns[i] = 1'b1;
                    l1[i] = 22'($urandom);
                    l2[i] = 22'($urandom);
                    rem[i] = $urandom_range(3, 1);
                end
            end
        end
        ns = '0;
        for (int i = 0; i < 2; i++) wait_idle("rand_drain", i, 3000);
        repeat (5) @(negedge clk);
        check("final_queue0_empty", exp_q[0].size(), 0);
        check("final_queue1_empty", exp_q[1].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
